// File: rtl/eth_tx_arbiter.sv
// Round-robin GMII transmit arbiter: grants one source per frame, forwards
// its bytes with one cycle of latency, enforces the inter-frame gap and
// aborts (tx_er marker + drain) on source underrun or oversize frames.
module eth_tx_arbiter #(
    parameter int N_SRC           = 4,
    parameter int IFG_CYCLES      = 12,
    parameter int MAX_FRAME_BYTES = 1526
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    output logic [N_SRC-1:0]   src_ready,
    output logic [7:0]         gmii_data_out,
    output logic               gmii_tx_en,
    output logic               gmii_tx_er,
    output logic [N_SRC-1:0]   grant,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_CYCLES - 2);
    localparam logic [15:0]      MAX_CNT   = 16'(MAX_FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_IFG} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [15:0]        r_byte_cnt, w_cnt_nxt;
    logic [IFG_W-1:0]   r_ifg_cnt, w_ifg_nxt;
    logic [N_SRC-1:0]   r_grant, w_grant_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_tx_en, w_en_nxt;
    logic               r_tx_er, w_er_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic [IDX_W:0]     w_pick;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;

    // First requester at or after ptr, wrapping; MSB of result flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N_SRC) cand = cand - N_SRC;
            if (req[cand]) res = {1'b1, IDX_W'(cand)};
        end
        return res;
    endfunction

    assign w_pick      = rr_pick(src_valid, r_rr_ptr);
    assign w_sel_valid = src_valid[r_gidx];
    assign w_sel_last  = src_last[r_gidx];
    assign w_sel_data  = src_data[8*r_gidx +: 8];

    assign gmii_data_out = r_data;
    assign gmii_tx_en    = r_tx_en;
    assign gmii_tx_er    = r_tx_er;
    assign grant         = r_grant;
    assign frame_done    = r_done;
    assign frame_err     = r_err;
    assign busy          = (r_state != S_IDLE);

    // State register and registered GMII/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_ifg_cnt  <= '0;
            r_grant    <= '0;
            r_data     <= '0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gidx     <= w_gidx_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_byte_cnt <= w_cnt_nxt;
            r_ifg_cnt  <= w_ifg_nxt;
            r_grant    <= w_grant_nxt;
            r_data     <= w_data_nxt;
            r_tx_en    <= w_en_nxt;
            r_tx_er    <= w_er_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state, handshake and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_byte_cnt;
        w_ifg_nxt   = r_ifg_cnt;
        w_grant_nxt = r_grant;
        w_data_nxt  = 8'h00;
        w_en_nxt    = 1'b0;
        w_er_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        src_ready   = '0;

        case (r_state)
            S_IDLE: begin
                if (w_pick[IDX_W]) begin
                    w_gidx_nxt  = w_pick[IDX_W-1:0];
                    w_grant_nxt = N_SRC'(1) << w_pick[IDX_W-1:0];
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_XFER;
                end
            end

            S_XFER: begin
                src_ready[r_gidx] = 1'b1;
                if (!w_sel_valid) begin
                    // Underrun: emit the abort marker, discard the rest.
                    w_en_nxt    = 1'b1;
                    w_er_nxt    = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (r_byte_cnt == MAX_CNT) begin
                    // Oversize: this byte is dropped and replaced by the marker.
                    // If it was the final byte there is nothing left to drain.
                    w_en_nxt = 1'b1;
                    w_er_nxt = 1'b1;
                    if (w_sel_last) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IFG;
                        w_grant_nxt = '0;
                        w_ifg_nxt   = '0;
                        w_rr_nxt    = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_sel_last) begin
                    w_en_nxt    = 1'b1;
                    w_data_nxt  = w_sel_data;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IFG;
                    w_grant_nxt = '0;
                    w_ifg_nxt   = '0;
                    w_rr_nxt    = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
                end else begin
                    w_en_nxt   = 1'b1;
                    w_data_nxt = w_sel_data;
                    w_cnt_nxt  = r_byte_cnt + 16'd1;
                end
            end

            S_DRAIN: begin
                src_ready[r_gidx] = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IFG;
                    w_grant_nxt = '0;
                    w_ifg_nxt   = '0;
                    w_rr_nxt    = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
                end
            end

            S_IFG: begin
                // IFG_CYCLES-1 cycles here plus the IDLE and first XFER cycles
                // give exactly IFG_CYCLES idle cycles on the wire.
                if (r_ifg_cnt == IFG_LAST) begin
                    w_ifg_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ifg_nxt = r_ifg_cnt + 1'b1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
